// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction byte queue between the instruction memory read port and the
// decoder. Memory returns 64-bit words tagged with the byte PC that requested
// them. Only the bytes that continue the current instruction stream are
// packed into a circular byte queue, and an 8-byte window starting at the
// oldest queued byte is presented to the decoder.
//
// Ports
//   clk         single clock
//   rst         synchronous active-high reset
//   mem_valid   mem_word / pc_to_fet valid this cycle
//   mem_word    64-bit memory word, byte k at [8k+7:8k]
//   pc_to_fet   byte PC that produced mem_word ([2:0] = first useful byte)
//   flush       branch redirect: drop all queued and arriving bytes
//   de_consume  bytes the decoder takes this cycle (clamped to fet_count)
//   stall_pc    PC must hold: not enough free space for in-flight words
//   fet_valid   window holds at least one byte
//   fet_bytes   8-byte window, byte 0 is the byte at fet_pc
//   fet_pc      byte address of fet_bytes[7:0]
//   fet_count   valid bytes in the window, min(count, 8)
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int LOAD_LATENCY = 1,
    parameter int QUEUE_BYTES  = 32,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [ADDR_W-1:0] pc_to_fet,
    input  logic              flush,
    input  logic [3:0]        de_consume,
    output logic              stall_pc,
    output logic              fet_valid,
    output logic [63:0]       fet_bytes,
    output logic [ADDR_W-1:0] fet_pc,
    output logic [3:0]        fet_count
);

    localparam int IDX_W    = $clog2(QUEUE_BYTES);
    localparam int CNT_W    = IDX_W + 1;
    localparam int HEADROOM = 8 * (LOAD_LATENCY + 1);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Registered state
    logic [0:0]        state_q,    state_d;
    logic [ADDR_W-1:0] head_pc_q,  head_pc_d;
    logic [ADDR_W-1:0] tail_pc_q,  tail_pc_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [IDX_W-1:0]  head_idx_q, head_idx_d;
    logic [IDX_W-1:0]  tail_idx_q, tail_idx_d;

    // Byte storage; contents beyond count are never observed, so no reset.
    logic [7:0] queue_q [QUEUE_BYTES];

    // Datapath helpers
    logic [3:0]        consume;
    logic [2:0]        start_byte;
    logic [3:0]        n_app;
    logic              addr_match;
    logic [CNT_W-1:0]  count_after_consume;
    logic [CNT_W:0]    count_sum;
    logic              fits;
    logic              accept;

    logic [7:0]        wr_en;
    logic [IDX_W-1:0]  wr_addr [8];
    logic [7:0]        wr_data [8];

    // -------------------------------------------------------------------------
    // Outputs: combinational from registered state only
    // -------------------------------------------------------------------------
    assign fet_count = (count_q >= CNT_W'(8)) ? 4'd8 : count_q[3:0];
    assign fet_valid = (count_q != '0) && (state_q == ST_RUN);
    assign fet_pc    = head_pc_q;
    // free < HEADROOM  <=>  count > QUEUE_BYTES - HEADROOM
    assign stall_pc  = (count_q > CNT_W'(QUEUE_BYTES - HEADROOM));

    for (genvar gi = 0; gi < 8; gi++) begin : g_window
        assign fet_bytes[8*gi +: 8] = (4'(gi) < fet_count)
                                    ? queue_q[head_idx_q + IDX_W'(gi)]
                                    : 8'h00;
    end

    // -------------------------------------------------------------------------
    // Accept / append decision
    // -------------------------------------------------------------------------
    assign consume    = (de_consume > fet_count) ? fet_count : de_consume;

    // In SYNC the word sets the stream start; in RUN only the bytes from the
    // expected tail onward are new, so overlapping words never duplicate.
    assign start_byte = (state_q == ST_SYNC) ? pc_to_fet[2:0] : tail_pc_q[2:0];
    assign n_app      = 4'd8 - {1'b0, start_byte};

    assign addr_match = (state_q == ST_SYNC) ||
                        ((pc_to_fet[ADDR_W-1:3] == tail_pc_q[ADDR_W-1:3]) &&
                         (pc_to_fet[2:0] <= tail_pc_q[2:0]));

    // Space check uses the post-consume count so a word can land in the same
    // cycle the decoder frees room for it.
    assign count_after_consume = count_q - CNT_W'(consume);
    assign count_sum           = {1'b0, count_after_consume} + (CNT_W+1)'(n_app);
    assign fits                = (count_sum <= (CNT_W+1)'(QUEUE_BYTES));

    assign accept = mem_valid && !flush && !rst && addr_match && fits;

    // One write lane per word byte; lane k lands at tail + (k - start_byte).
    for (genvar gi = 0; gi < 8; gi++) begin : g_wr_lane
        assign wr_en[gi]   = accept && (3'(gi) >= start_byte);
        assign wr_addr[gi] = tail_idx_q + IDX_W'(gi) - IDX_W'(start_byte);
        assign wr_data[gi] = mem_word[8*gi +: 8];
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        head_pc_d  = head_pc_q;
        tail_pc_d  = tail_pc_q;
        count_d    = count_q;
        head_idx_d = head_idx_q;
        tail_idx_d = tail_idx_q;

        if (flush) begin
            // Flush beats append and consume; head_pc is left as-is because
            // the next accepted word reloads it.
            state_d    = ST_SYNC;
            count_d    = '0;
            head_idx_d = '0;
            tail_idx_d = '0;
        end else begin
            head_pc_d  = head_pc_q + ADDR_W'(consume);
            head_idx_d = head_idx_q + IDX_W'(consume);
            count_d    = count_after_consume;

            if (accept) begin
                count_d    = count_after_consume + CNT_W'(n_app);
                tail_idx_d = tail_idx_q + IDX_W'(n_app);
                tail_pc_d  = {pc_to_fet[ADDR_W-1:3] + (ADDR_W-3)'(1), 3'b000};
                state_d    = ST_RUN;
                if (state_q == ST_SYNC) begin
                    head_pc_d = pc_to_fet;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            head_pc_q  <= '0;
            tail_pc_q  <= '0;
            count_q    <= '0;
            head_idx_q <= '0;
            tail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            head_pc_q  <= head_pc_d;
            tail_pc_q  <= tail_pc_d;
            count_q    <= count_d;
            head_idx_q <= head_idx_d;
            tail_idx_q <= tail_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (wr_en[k]) begin
                queue_q[wr_addr[k]] <= wr_data[k];
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed stimulus for fetch_buffer (QUEUE_BYTES=32, LOAD_LATENCY=1). Each
// stimulus cycle pushes the hand-derived window expected one cycle later into
// a scoreboard queue; an independent monitor pops entries on the falling edge
// of the cycle they target and compares them with the DUT outputs.
// Memory words are modelled so that byte k of the word for aligned address A
// equals (A+k) & 8'hFF, which makes every window easy to derive by hand.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [63:0] mem_word;
    logic [31:0] pc_to_fet;
    logic        flush;
    logic [3:0]  de_consume;
    logic        stall_pc;
    logic        fet_valid;
    logic [63:0] fet_bytes;
    logic [31:0] fet_pc;
    logic [3:0]  fet_count;

    fetch_buffer #(
        .LOAD_LATENCY(1),
        .QUEUE_BYTES (32),
        .ADDR_W      (32),
        .DATA_W      (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_word   (mem_word),
        .pc_to_fet  (pc_to_fet),
        .flush      (flush),
        .de_consume (de_consume),
        .stall_pc   (stall_pc),
        .fet_valid  (fet_valid),
        .fet_bytes  (fet_bytes),
        .fet_pc     (fet_pc),
        .fet_count  (fet_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        valid;
        logic        chk_pc;
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic [63:0] bytes;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   cycle_cnt = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Memory word for the aligned address containing pc.
    function automatic logic [63:0] word_at(input logic [31:0] pc);
        logic [31:0] base;
        logic [63:0] w;
        base = {pc[31:3], 3'b000};
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[8*k +: 8] = 8'(base + 32'(k));
        end
        return w;
    endfunction

    // Window of n bytes starting at pc under the word model above.
    function automatic logic [63:0] win(input logic [31:0] pc, input int n);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[8*k +: 8] = 8'(pc + 32'(k));
        end
        return w;
    endfunction

    task automatic check(input string name, input string field,
                         input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: compare entries whose target cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
            e = sb.pop_front();
            if (e.cyc < cycle_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.missed: got cycle %0d, expected cycle %0d",
                         e.name, cycle_cnt, e.cyc);
            end else begin
                check(e.name, "fet_valid", 64'(fet_valid), 64'(e.valid));
                check(e.name, "fet_count", 64'(fet_count), 64'(e.cnt));
                check(e.name, "fet_bytes", fet_bytes, e.bytes);
                check(e.name, "stall_pc",  64'(stall_pc),  64'(e.stall));
                if (e.chk_pc) begin
                    check(e.name, "fet_pc", 64'(fet_pc), 64'(e.pc));
                end
                $display("[cyc %0d] %-16s valid=%0b pc=0x%0h count=%0d bytes=0x%016h stall=%0b",
                         cycle_cnt, e.name, fet_valid, fet_pc, fet_count, fet_bytes, stall_pc);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after its edge.
    task automatic step(input logic r, input logic mv, input logic [31:0] pc,
                        input logic fl, input logic [3:0] cons, input string name,
                        input logic ev, input logic cp, input logic [31:0] epc,
                        input logic [3:0] ecnt, input logic [63:0] eb, input logic es);
        exp_t e;
        @(negedge clk);
        rst        = r;
        mem_valid  = mv;
        pc_to_fet  = pc;
        mem_word   = word_at(pc);
        flush      = fl;
        de_consume = cons;
        e.cyc    = cycle_cnt + 1;
        e.name   = name;
        e.valid  = ev;
        e.chk_pc = cp;
        e.pc     = epc;
        e.cnt    = ecnt;
        e.bytes  = eb;
        e.stall  = es;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_word = '0; pc_to_fet = '0;
        flush = 1'b0; de_consume = '0;

        // r mv pc       fl cons name                 ev cp pc      cnt bytes               stall
        step(1, 0, 32'h0,   0, 0, "reset",            0, 1, 32'h0,   0, 64'h0,               0);
        step(0, 1, 32'h103, 0, 0, "sync_unaligned",   1, 1, 32'h103, 5, 64'h0000000706050403, 0);
        step(0, 1, 32'h101, 0, 0, "drop_stale",       1, 1, 32'h103, 5, win(32'h103, 5),     0);
        step(0, 1, 32'h110, 0, 0, "drop_skip",        1, 1, 32'h103, 5, win(32'h103, 5),     0);
        step(0, 1, 32'h10A, 0, 0, "drop_offset",      1, 1, 32'h103, 5, win(32'h103, 5),     0);
        step(0, 1, 32'h108, 0, 0, "accept_next",      1, 1, 32'h103, 8, 64'h0A09080706050403, 0);
        step(0, 0, 32'h0,   0, 15, "consume_clamp",   1, 1, 32'h10B, 5, 64'h0000000F0E0D0C0B, 0);
        step(1, 1, 32'h110, 0, 0, "reset_mid",        0, 1, 32'h0,   0, 64'h0,               0);
        step(0, 1, 32'h100, 0, 0, "sync_aligned",     1, 1, 32'h100, 8, 64'h0706050403020100, 0);
        step(0, 0, 32'h0,   0, 0, "hold",             1, 1, 32'h100, 8, 64'h0706050403020100, 0);
        step(0, 1, 32'h108, 0, 3, "append_consume",   1, 1, 32'h103, 8, 64'h0A09080706050403, 0);
        step(0, 0, 32'h0,   0, 5, "consume5",         1, 1, 32'h108, 8, win(32'h108, 8),     0);
        step(0, 1, 32'h110, 0, 0, "fill16",           1, 1, 32'h108, 8, win(32'h108, 8),     0);
        step(0, 1, 32'h118, 0, 0, "fill24_stall",     1, 1, 32'h108, 8, win(32'h108, 8),     1);
        step(0, 1, 32'h120, 0, 0, "fill32",           1, 1, 32'h108, 8, win(32'h108, 8),     1);
        step(0, 1, 32'h128, 0, 0, "overflow_drop",    1, 1, 32'h108, 8, win(32'h108, 8),     1);
        step(0, 1, 32'h128, 0, 8, "replay",           1, 1, 32'h110, 8, win(32'h110, 8),     1);
        step(0, 0, 32'h0,   0, 8, "drain24",          1, 1, 32'h118, 8, win(32'h118, 8),     1);
        step(0, 0, 32'h0,   0, 8, "drain16",          1, 1, 32'h120, 8, win(32'h120, 8),     0);
        step(0, 0, 32'h0,   0, 8, "drain8",           1, 1, 32'h128, 8, win(32'h128, 8),     0);
        step(0, 0, 32'h0,   0, 8, "drain0",           0, 1, 32'h130, 0, 64'h0,               0);
        step(0, 1, 32'h130, 0, 0, "refill",           1, 1, 32'h130, 8, win(32'h130, 8),     0);
        step(0, 1, 32'h138, 1, 0, "flush1",           0, 0, 32'h0,   0, 64'h0,               0);
        step(0, 1, 32'h140, 1, 0, "flush2",           0, 0, 32'h0,   0, 64'h0,               0);
        step(0, 0, 32'h0,   0, 0, "post_flush_idle",  0, 0, 32'h0,   0, 64'h0,               0);
        step(0, 1, 32'h200, 0, 0, "redirect",         1, 1, 32'h200, 8, 64'h0706050403020100, 0);

        @(negedge clk);
        mem_valid = 1'b0; flush = 1'b0; de_consume = '0;

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
